// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite blitter: command encodings, FSM states,
// pass types and default screen size.
package sprite_pkg;

  localparam logic [1:0] CMD_ERASE = 2'b00;
  localparam logic [1:0] CMD_DRAW  = 2'b01;
  localparam logic [1:0] CMD_MOVE  = 2'b10;
  localparam logic [1:0] CMD_RSVD  = 2'b11;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADDR  = 3'd2,
    FETCH = 3'd3,
    PLOT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  typedef enum logic {
    PASS_BG  = 1'b0,
    PASS_SPR = 1'b1
  } pass_e;

  // Counter width that stays at least one bit for degenerate 1-pixel sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_counter.sv
// Column/row raster counter over a SPRITE_W x SPRITE_H rectangle, with the
// post-advance value exposed so the next pixel address can be registered early.
module blit_counter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  localparam int CW = cnt_width(SPRITE_W),
  localparam int RW = cnt_width(SPRITE_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col_next,
  output logic [RW-1:0] row_next,
  output logic          last
);

  // Next raster position with column wrap into the following row.
  always_comb begin
    col_next = col + CW'(1);
    row_next = row;
    if (col == CW'(SPRITE_W - 1)) begin
      col_next = '0;
      if (row == RW'(SPRITE_H - 1)) begin
        row_next = '0;
      end else begin
        row_next = row + RW'(1);
      end
    end else begin
      row_next = row;
    end
  end

  assign last = (col == CW'(SPRITE_W - 1)) && (row == RW'(SPRITE_H - 1));

  // Position register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= col_next;
      row <= row_next;
    end else begin
      col <= col;
      row <= row;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite renderer: ERASE/DRAW/MOVE a SPRITE_W x SPRITE_H rectangle from ROMs to VGA.
// Optional feature macro: SPRITE_TRANSPARENCY_EN (skip sprite pixels of TRANSPARENT_COLOR).
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int X_W = 9,
  parameter int Y_W = 8,
  parameter int COLOR_W = 3,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = '0,
  localparam int AW = cnt_width(SPRITE_W * SPRITE_H)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         cmd,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  output logic               busy,
  output logic               done,
  output logic [X_W-1:0]     bg_x,
  output logic [Y_W-1:0]     bg_y,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [AW-1:0]      spr_addr,
  input  logic [COLOR_W-1:0] spr_color,
  output logic               plot,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic [X_W-1:0]     last_x,
  output logic [Y_W-1:0]     last_y
);

  localparam int CW = cnt_width(SPRITE_W);
  localparam int RW = cnt_width(SPRITE_H);

  state_e         state;
  logic [1:0]     op;
  logic           pass2;
  pass_e          ptype;
  logic [X_W-1:0] base_x, tgt_x, nb_x;
  logic [Y_W-1:0] base_y, tgt_y, nb_y;
  pass_e          ntype;
  logic [CW-1:0]  col, col_next;
  logic [RW-1:0]  row, row_next;
  logic           last_pix;
  logic [X_W:0]   px;
  logic [Y_W:0]   py;
  logic           skip;
  logic [AW-1:0]  nxt_addr;

  blit_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == LOAD),
    .advance  (state == PLOT),
    .col      (col),
    .row      (row),
    .col_next (col_next),
    .row_next (row_next),
    .last     (last_pix)
  );

`ifndef SPRITE_TRANSPARENCY_EN
  logic unused_transparent;
  assign unused_transparent = ^TRANSPARENT_COLOR;
`endif

  // Pixel coordinate, skip decision, next ROM address and next pass setup.
  always_comb begin
    px       = {1'b0, base_x} + (X_W + 1)'(col);
    py       = {1'b0, base_y} + (Y_W + 1)'(row);
`ifdef SPRITE_TRANSPARENCY_EN
    skip     = (px >= (X_W + 1)'(SCREEN_W)) || (py >= (Y_W + 1)'(SCREEN_H)) ||
               ((ptype == PASS_SPR) && (spr_color == TRANSPARENT_COLOR));
`else
    skip     = (px >= (X_W + 1)'(SCREEN_W)) || (py >= (Y_W + 1)'(SCREEN_H));
`endif
    nxt_addr = AW'(row_next) * AW'(SPRITE_W) + AW'(col_next);
    nb_x     = tgt_x;
    nb_y     = tgt_y;
    ntype    = PASS_BG;
    case (op)
      CMD_ERASE: ntype = PASS_BG;
      CMD_DRAW:  ntype = PASS_SPR;
      CMD_MOVE: begin
        if (pass2) begin
          ntype = PASS_SPR;
        end else begin
          nb_x  = last_x;
          nb_y  = last_y;
          ntype = PASS_BG;
        end
      end
      default: ntype = PASS_BG;
    endcase
  end

  // Command FSM; every output is registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= CMD_ERASE;
      pass2     <= 1'b0;
      ptype     <= PASS_BG;
      base_x    <= '0;
      base_y    <= '0;
      tgt_x     <= '0;
      tgt_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      plot      <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      bg_x      <= '0;
      bg_y      <= '0;
      spr_addr  <= '0;
      last_x    <= '0;
      last_y    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (start && (cmd != CMD_RSVD)) begin
            op    <= cmd;
            tgt_x <= x_in;
            tgt_y <= y_in;
            pass2 <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          base_x   <= nb_x;
          base_y   <= nb_y;
          ptype    <= ntype;
          bg_x     <= nb_x;
          bg_y     <= nb_y;
          spr_addr <= '0;
          state    <= ADDR;
        end
        ADDR: state <= FETCH;
        FETCH: begin
          plot      <= ~skip;
          x_out     <= px[X_W-1:0];
          y_out     <= py[Y_W-1:0];
          color_out <= (ptype == PASS_SPR) ? spr_color : bg_color;
          state     <= PLOT;
        end
        PLOT: begin
          plot <= 1'b0;
          if (!last_pix) begin
            bg_x     <= base_x + X_W'(col_next);
            bg_y     <= base_y + Y_W'(row_next);
            spr_addr <= nxt_addr;
            state    <= ADDR;
          end else if ((op == CMD_MOVE) && !pass2) begin
            pass2 <= 1'b1;
            state <= LOAD;
          end else begin
            done  <= 1'b1;
            state <= DONE;
            if (ptype == PASS_SPR) begin
              last_x <= base_x;
              last_y <= base_y;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with behavioural background/sprite ROMs.
module tb_sprite_blitter;
  import sprite_pkg::*;

  logic       clock = 1'b0;
  logic       reset, start;
  logic [1:0] cmd;
  logic [8:0] x_in, bg_x, x_out, last_x;
  logic [7:0] y_in, bg_y, y_out, last_y;
  logic [2:0] bg_color, spr_color, color_out;
  logic [3:0] spr_addr;
  logic       busy, done, plot;
  logic [2:0] rom [16];

  int checks = 0;
  int errors = 0;
  int qx[$], qy[$], qc[$];
  int ex[$], ey[$], ec[$];
  int cyc;

  sprite_blitter dut (
    .clock(clock), .reset(reset), .start(start), .cmd(cmd), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .bg_x(bg_x), .bg_y(bg_y), .bg_color(bg_color),
    .spr_addr(spr_addr), .spr_color(spr_color), .plot(plot), .x_out(x_out),
    .y_out(y_out), .color_out(color_out), .last_x(last_x), .last_y(last_y)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    bg_color  <= 3'(bg_x + 9'(bg_y));
    spr_color <= rom[spr_addr];
  end

  always @(negedge clock) begin
    if (plot === 1'b1) begin
      qx.push_back(int'(x_out));
      qy.push_back(int'(y_out));
      qc.push_back(int'(color_out));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind 0: background colour (x+y)&7; 1: sprite colour 4; 2: sprite, diagonal transparent
  task automatic expect_rect(input int bx, input int by, input int kind);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ((bx + c < 320) && (by + r < 240) && !(kind == 2 && r == c)) begin
          ex.push_back(bx + c);
          ey.push_back(by + r);
          ec.push_back((kind == 0) ? ((bx + c + by + r) & 7) : 4);
        end
      end
    end
  endtask

  task automatic compare_plots(input string tag);
    logic [63:0] obs, exp;
    check({tag, "_count"}, 64'(qx.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size(); i++) begin
      exp = 64'(ex[i] * 100000 + ey[i] * 10 + ec[i]);
      obs = (i < qx.size()) ? 64'(qx[i] * 100000 + qy[i] * 10 + qc[i]) : '1;
      check($sformatf("%s_px%0d", tag, i), obs, exp);
    end
    ex.delete(); ey.delete(); ec.delete();
  endtask

  // Issue one command; cycle 1 is the cycle after the accepting edge.
  task automatic run(input logic [1:0] c, input int x, input int y, input int poke,
                     output int ncyc);
    qx.delete(); qy.delete(); qc.delete();
    ncyc = -1;
    @(negedge clock);
    start = 1'b1; cmd = c; x_in = 9'(x); y_in = 8'(y);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if (n == poke) begin
        start = 1'b1; cmd = CMD_ERASE; x_in = 9'd100; y_in = 8'd100;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ncyc = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cmd = 2'b00; x_in = '0; y_in = '0;
    for (int i = 0; i < 16; i++) rom[i] = 3'b100;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ctrl", {61'd0, busy, done, plot}, 64'd0);
    check("rst_out", {x_out, y_out, color_out}, 64'd0);
    check("rst_rom", {bg_x, bg_y, spr_addr}, 64'd0);
    check("rst_last", {last_x, last_y}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // DRAW at (10,20)
    run(CMD_DRAW, 10, 20, 0, cyc);
    check("draw_cycles", 64'(cyc), 64'd50);
    expect_rect(10, 20, 1);
    compare_plots("draw");
    check("draw_last", {last_x, last_y}, {9'd10, 8'd20});
    @(negedge clock);
    check("draw_idle", {62'd0, busy, done}, 64'd0);

    // ERASE at (10,20): background colour (x+y)&7
    run(CMD_ERASE, 10, 20, 0, cyc);
    check("erase_cycles", 64'(cyc), 64'd50);
    check("erase_12_21", (qc.size() > 6) ? 64'(qc[6]) : '1, 64'd1);
    expect_rect(10, 20, 0);
    compare_plots("erase");
    check("erase_last", {last_x, last_y}, {9'd10, 8'd20});

    // MOVE to (11,20): erase old rectangle then draw at the new one
    run(CMD_MOVE, 11, 20, 0, cyc);
    check("move_cycles", 64'(cyc), 64'd99);
    expect_rect(10, 20, 0);
    expect_rect(11, 20, 1);
    compare_plots("move");
    check("move_last", {last_x, last_y}, {9'd11, 8'd20});

    // DRAW clipped at the bottom-right corner
    run(CMD_DRAW, 318, 238, 0, cyc);
    check("clip_cycles", 64'(cyc), 64'd50);
    expect_rect(318, 238, 1);
    compare_plots("clip");
    check("clip_last", {last_x, last_y}, {9'd318, 8'd238});

    // Reserved command in IDLE does nothing
    qx.delete(); qy.delete(); qc.delete();
    @(negedge clock);
    start = 1'b1; cmd = CMD_RSVD; x_in = 9'd1; y_in = 8'd1;
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clock);
        start = 1'b0;
        seen = seen | busy | done | plot;
      end
      check("rsvd_activity", {63'd0, seen}, 64'd0);
    end
    check("rsvd_plots", 64'(qx.size()), 64'd0);

    // start while busy (with changed inputs) is ignored
    run(CMD_DRAW, 5, 6, 3, cyc);
    check("busy_cycles", 64'(cyc), 64'd50);
    expect_rect(5, 6, 1);
    compare_plots("busy");
    check("busy_last", {last_x, last_y}, {9'd5, 8'd6});
    repeat (3) @(negedge clock);
    check("busy_no_restart", {63'd0, busy}, 64'd0);

    // Reset in cycle 7 of a DRAW (second pixel's plot cycle)
    @(negedge clock);
    start = 1'b1; cmd = CMD_DRAW; x_in = 9'd40; y_in = 8'd40;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    check("mid_plot_high", {62'd0, plot, busy}, 64'd3);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ctrl", {62'd0, plot, busy}, 64'd0);
    check("mid_rst_last", {last_x, last_y}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst_idle", {62'd0, busy, done}, 64'd0);

`ifdef SPRITE_TRANSPARENCY_EN
    for (int i = 0; i < 4; i++) rom[i * 5] = 3'b000;
    run(CMD_DRAW, 50, 60, 0, cyc);
    check("transp_cycles", 64'(cyc), 64'd50);
    expect_rect(50, 60, 2);
    compare_plots("transp");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
